// File: rtl/i2c_pkg.sv
// Shared I2C/SHT40 definitions: master state codes, sensor constants,
// and the measurement sequencer state type.
package i2c_pkg;

   localparam logic [2:0] MASTER_PROCESSOR = 3'b000;
   localparam logic [2:0] MASTER_START     = 3'b001;
   localparam logic [2:0] MASTER_ADDRESS   = 3'b010;
   localparam logic [2:0] MASTER_ACK       = 3'b011;
   localparam logic [2:0] MASTER_WRITE     = 3'b100;
   localparam logic [2:0] MASTER_READ      = 3'b101;
   localparam logic [2:0] MASTER_END       = 3'b110;

   localparam logic [6:0] SHT40_ADDR       = 7'h44;
   localparam logic [7:0] MEAS_CMD_HIGH    = 8'hFD;
   localparam logic [7:0] CRC_POLY         = 8'h31;
   localparam logic [7:0] CRC_INIT         = 8'hFF;
   localparam int         SHT40_READ_BYTES = 6;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_SEND_CMD,
      SEQ_WAIT_LEAVE_W,
      SEQ_WAIT_DONE_W,
      SEQ_MEAS_WAIT,
      SEQ_SEND_RD,
      SEQ_COLLECT,
      SEQ_CHECK
   } seq_state_t;

endpackage

// File: rtl/sht40_crc8.sv
// SHT40 CRC-8 over one 16-bit word (poly 0x31, init 0xFF, MSB first).
// Ports: data (16-bit word, first byte in [15:8]) -> crc (8-bit).
module sht40_crc8
   import i2c_pkg::*;
(
   input  logic [15:0] data,
   output logic [7:0]  crc
);

   logic [7:0] c;
   logic       fb;

   always_comb begin
      c  = CRC_INIT;
      fb = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         fb = c[7] ^ data[i];
         c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
      crc = c;
   end

endmodule

// File: rtl/sht40_sequencer.sv
// SHT40 measurement sequencer driving the processor side of i2c_master.
// Ports: clk/rst, meas_start/busy, master request/status, result strobes.
module sht40_sequencer
   import i2c_pkg::*;
#(
   parameter logic [6:0] SENSOR_ADDR    = SHT40_ADDR,
   parameter logic [7:0] MEAS_CMD       = MEAS_CMD_HIGH,
   parameter int         WAIT_CYCLES    = 200000,
   parameter int         TIMEOUT_CYCLES = 2000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        meas_start,
   output logic        Processor_Ready,
   output logic [6:0]  Peripheral_Address,
   output logic [7:0]  Command_Data_Frames,
   output logic        r_or_w,
   output logic        i2c_writes,
   output logic [3:0]  SHT_Reads,
   output logic        CRC_Error,
   input  logic [2:0]  Master_State_Out,
   input  logic [7:0]  Data_Received,
   input  logic [3:0]  Output_Received_Counter,
   output logic [15:0] temp_raw,
   output logic [15:0] hum_raw,
   output logic        meas_valid,
   output logic        crc_fail,
   output logic        timeout_err,
   output logic        busy
);

   localparam int WW = $clog2(WAIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0] LAST_IDX = 3'(SHT40_READ_BYTES - 1);

   seq_state_t    state, next;
   logic [WW-1:0] wcnt;
   logic [TW-1:0] tcnt;
   logic [3:0]    cnt_q;
   logic [2:0]    idx;
   logic [7:0]    rx_buf [SHT40_READ_BYTES];
   logic [7:0]    crc_t, crc_h;
   logic          byte_stb, timing, tout, wait_done, crc_ok;

   assign Peripheral_Address  = SENSOR_ADDR;
   assign Command_Data_Frames = MEAS_CMD;
   assign i2c_writes          = 1'b0;
   assign SHT_Reads           = 4'(SHT40_READ_BYTES - 1);

   sht40_crc8 u_crc_t (.data({rx_buf[0], rx_buf[1]}), .crc(crc_t));
   sht40_crc8 u_crc_h (.data({rx_buf[3], rx_buf[4]}), .crc(crc_h));

   assign crc_ok = (crc_t == rx_buf[2]) && (crc_h == rx_buf[5]);

   // A change in the master byte counter marks a newly received byte.
   assign byte_stb  = (Output_Received_Counter != cnt_q);
   assign timing    = (state == SEQ_WAIT_LEAVE_W) ||
                      (state == SEQ_WAIT_DONE_W)  ||
                      (state == SEQ_COLLECT);
   assign tout      = timing && (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign wait_done = (wcnt == WW'(WAIT_CYCLES - 1));

   always_comb begin
      next            = state;
      Processor_Ready = 1'b0;
      r_or_w          = 1'b0;
      busy            = 1'b1;
      unique case (state)
         SEQ_IDLE: begin
            busy = 1'b0;
            if (meas_start) next = SEQ_SEND_CMD;
         end
         SEQ_SEND_CMD: begin
            Processor_Ready = 1'b1;
            next            = SEQ_WAIT_LEAVE_W;
         end
         SEQ_WAIT_LEAVE_W: begin
            if (tout)
               next = SEQ_IDLE;
            else if (Master_State_Out != MASTER_PROCESSOR)
               next = SEQ_WAIT_DONE_W;
         end
         SEQ_WAIT_DONE_W: begin
            if (tout)
               next = SEQ_IDLE;
            else if (Master_State_Out == MASTER_PROCESSOR)
               next = SEQ_MEAS_WAIT;
         end
         SEQ_MEAS_WAIT: begin
            if (wait_done) next = SEQ_SEND_RD;
         end
         SEQ_SEND_RD: begin
            Processor_Ready = 1'b1;
            r_or_w          = 1'b1;
            next            = SEQ_COLLECT;
         end
         SEQ_COLLECT: begin
            r_or_w = 1'b1;
            if (tout)
               next = SEQ_IDLE;
            else if (byte_stb && idx == LAST_IDX)
               next = SEQ_CHECK;
         end
         SEQ_CHECK: begin
            r_or_w = 1'b1;
            next   = SEQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SEQ_IDLE;
         wcnt        <= '0;
         tcnt        <= '0;
         cnt_q       <= '0;
         idx         <= '0;
         temp_raw    <= '0;
         hum_raw     <= '0;
         meas_valid  <= 1'b0;
         crc_fail    <= 1'b0;
         timeout_err <= 1'b0;
         CRC_Error   <= 1'b0;
         for (int i = 0; i < SHT40_READ_BYTES; i++) rx_buf[i] <= '0;
      end else begin
         state <= next;
         cnt_q <= Output_Received_Counter;
         wcnt  <= (state == SEQ_MEAS_WAIT) ? wcnt + 1'b1 : '0;

         if (state == SEQ_SEND_CMD || state == SEQ_SEND_RD)
            tcnt <= '0;
         else if (timing)
            tcnt <= tcnt + 1'b1;

         if (state == SEQ_SEND_RD) begin
            idx <= '0;
         end else if (state == SEQ_COLLECT && byte_stb) begin
            rx_buf[idx] <= Data_Received;
            idx         <= idx + 1'b1;
         end

         meas_valid  <= (state == SEQ_CHECK) && crc_ok;
         crc_fail    <= (state == SEQ_CHECK) && !crc_ok;
         timeout_err <= tout;
         CRC_Error   <= tout || ((state == SEQ_CHECK) && !crc_ok);

         if (state == SEQ_CHECK && crc_ok) begin
            temp_raw <= {rx_buf[0], rx_buf[1]};
            hum_raw  <= {rx_buf[3], rx_buf[4]};
         end
      end
   end

endmodule

// File: tb/tb_sht40_sequencer.sv
// Scoreboard bench for sht40_sequencer with a behavioural i2c_master model.
// Ports: none (top-level testbench).
module tb_sht40_sequencer;

   localparam int W = 50;
   localparam int T = 100;
   localparam int K_VALID = 0;
   localparam int K_CRC   = 1;
   localparam int K_TO    = 2;

   typedef struct {
      int          kind;
      logic [15:0] t;
      logic [15:0] h;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, meas_start;
   logic        Processor_Ready, r_or_w, i2c_writes, CRC_Error;
   logic [6:0]  Peripheral_Address;
   logic [7:0]  Command_Data_Frames, Data_Received;
   logic [3:0]  SHT_Reads, Output_Received_Counter;
   logic [2:0]  Master_State_Out;
   logic [15:0] temp_raw, hum_raw;
   logic        meas_valid, crc_fail, timeout_err, busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q[$];
   logic [7:0] rb [6];
   logic hang = 1'b0;
   int   wr_cnt = 0, rd_cnt = 0, wr_done_cnt = 0;
   int   wr_cyc = 0, mso0_cyc = 0, to_cyc = 0;
   logic mso0_ok = 1'b0;
   logic prev_err = 1'b0;
   logic chk_busy = 1'b0;

   sht40_sequencer #(.WAIT_CYCLES(W), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .meas_start(meas_start),
      .Processor_Ready(Processor_Ready),
      .Peripheral_Address(Peripheral_Address),
      .Command_Data_Frames(Command_Data_Frames),
      .r_or_w(r_or_w), .i2c_writes(i2c_writes), .SHT_Reads(SHT_Reads),
      .CRC_Error(CRC_Error), .Master_State_Out(Master_State_Out),
      .Data_Received(Data_Received),
      .Output_Received_Counter(Output_Received_Counter),
      .temp_raw(temp_raw), .hum_raw(hum_raw), .meas_valid(meas_valid),
      .crc_fail(crc_fail), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Master model: responds to Processor_Ready requests.
   initial begin
      Master_State_Out = 3'b000;
      Data_Received = 8'h00;
      Output_Received_Counter = 4'd0;
      forever begin
         @(negedge clk);
         if (Processor_Ready && !rst) begin
            if (!r_or_w) begin
               wr_cnt++;
               wr_cyc = cyc;
               chk("wr_addr", 32'(Peripheral_Address), 32'h44);
               chk("wr_cmd", 32'(Command_Data_Frames), 32'hFD);
               if (!hang) begin
                  repeat (2) @(negedge clk);
                  Master_State_Out = 3'b001;
                  repeat (5) @(negedge clk);
                  Master_State_Out = 3'b000;
                  mso0_cyc = cyc;
                  mso0_ok = 1'b1;
                  wr_done_cnt++;
               end
            end else begin
               rd_cnt++;
               if (mso0_ok) chk("rd_delay", 32'(cyc - mso0_cyc), 32'(W + 1));
               mso0_ok = 1'b0;
               Master_State_Out = 3'b101;
               for (int k = 0; k < 6; k++) begin
                  repeat (3) @(negedge clk);
                  Data_Received = rb[k];
                  Output_Received_Counter = 4'((k + 1) % 6);
                  if (k == 2) chk("rd_r_or_w", 32'(r_or_w), 32'd1);
               end
               repeat (2) @(negedge clk);
               Master_State_Out = 3'b000;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every result strobe.
   always @(negedge clk) begin
      exp_t e;
      logic [2:0] ev;
      if (rst) begin
         prev_err = 1'b0;
         chk_busy = 1'b0;
      end else begin
         if (chk_busy) chk("busy_after_strobe", 32'(busy), 32'd0);
         chk_busy = 1'b0;
         if (meas_valid || crc_fail || timeout_err) begin
            if (timeout_err) to_cyc = cyc;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: mv=%b cf=%b te=%b",
                        meas_valid, crc_fail, timeout_err);
            end else begin
               e = q.pop_front();
               ev = (e.kind == K_VALID) ? 3'b100 :
                    (e.kind == K_CRC)   ? 3'b010 : 3'b001;
               chk("strobe_kind", 32'({meas_valid, crc_fail, timeout_err}),
                   32'(ev));
               chk("temp_raw", 32'(temp_raw), 32'(e.t));
               chk("hum_raw", 32'(hum_raw), 32'(e.h));
               chk("crc_error", 32'(CRC_Error), 32'(e.kind != K_VALID));
               chk_busy = 1'b1;
            end
         end else if (CRC_Error) begin
            checks++;
            errors++;
            $display("FAIL crc_error_alone: got 1 expected 0");
         end
         if (CRC_Error && prev_err) begin
            checks++;
            errors++;
            $display("FAIL crc_error_width: got 2+ cycles expected 1");
         end
         prev_err = CRC_Error;
      end
   end

   task automatic set_bytes(input logic [47:0] b);
      for (int k = 0; k < 6; k++) rb[k] = b[47 - 8*k -: 8];
   endtask

   task automatic pulse_start();
      @(negedge clk);
      meas_start = 1'b1;
      @(negedge clk);
      meas_start = 1'b0;
   endtask

   task automatic wait_idle(string n);
      int i;
      for (i = 0; i < 3000; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      if (i == 3000) begin
         checks++;
         errors++;
         $display("FAIL %s: got busy after 3000 cycles expected idle", n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input logic [47:0] b, input int k,
                      input logic [15:0] t, input logic [15:0] h, string n);
      set_bytes(b);
      q.push_back('{kind: k, t: t, h: h});
      pulse_start();
      chk({n, "_busy"}, 32'(busy), 32'd1);
      wait_idle(n);
   endtask

   initial begin
      int rd0, i;
      rst = 1'b1;
      meas_start = 1'b0;
      set_bytes(48'h0);
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pr", 32'(Processor_Ready), 32'd0);
      chk("rst_rw", 32'(r_or_w), 32'd0);
      chk("rst_strobes",
          32'({meas_valid, crc_fail, timeout_err, CRC_Error}), 32'd0);
      chk("rst_temp", 32'(temp_raw), 32'd0);
      chk("rst_hum", 32'(hum_raw), 32'd0);
      chk("rst_addr", 32'(Peripheral_Address), 32'h44);
      chk("rst_cmd", 32'(Command_Data_Frames), 32'hFD);
      chk("rst_reads", 32'(SHT_Reads), 32'd5);
      chk("rst_writes", 32'(i2c_writes), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(48'hBEEF92666693, K_VALID, 16'hBEEF, 16'h6666, "good");
      run(48'hBEEF93666693, K_CRC, 16'hBEEF, 16'h6666, "badcrc");

      // Requests during COLLECT must be dropped.
      set_bytes(48'h000081BEEF92);
      q.push_back('{kind: K_VALID, t: 16'h0000, h: 16'hBEEF});
      pulse_start();
      for (i = 0; i < 500 && !r_or_w; i++) @(negedge clk);
      chk("reach_collect", 32'(r_or_w), 32'd1);
      for (i = 0; i < 200 && r_or_w; i++) begin
         meas_start = 1'b1;
         @(negedge clk);
      end
      meas_start = 1'b0;
      wait_idle("hammer");
      chk("hammer_idle", 32'(busy), 32'd0);
      run(48'hBEEF92666693, K_VALID, 16'hBEEF, 16'h6666, "after_hammer");

      // Master never leaves idle after the write request.
      hang = 1'b1;
      rd0 = rd_cnt;
      q.push_back('{kind: K_TO, t: 16'hBEEF, h: 16'h6666});
      pulse_start();
      wait_idle("timeout");
      chk("to_delay", 32'(to_cyc - wr_cyc), 32'(T + 1));
      chk("to_no_read", 32'(rd_cnt), 32'(rd0));
      hang = 1'b0;

      // Reset while in MEAS_WAIT.
      set_bytes(48'hBEEF92666693);
      i = wr_done_cnt;
      pulse_start();
      for (int j = 0; j < 200 && wr_done_cnt == i; j++) @(negedge clk);
      chk("rst_wr_done", 32'(wr_done_cnt), 32'(i + 1));
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_strobes",
          32'({meas_valid, crc_fail, timeout_err, CRC_Error}), 32'd0);
      chk("mid_rst_temp", 32'(temp_raw), 32'd0);
      rst = 1'b0;
      repeat (W + 20) @(negedge clk);
      chk("mid_rst_quiet", 32'(busy), 32'd0);
      run(48'hBEEF92666693, K_VALID, 16'hBEEF, 16'h6666, "restart");

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
